// File: rtl/bram_dp.sv
// Simple dual-port RAM: byte-enabled write port, independent pipelined read port,
// selectable collision mode and a clear engine that sweeps CLR_VAL through every word.
module bram_dp #(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       LEN     = 2048,
  parameter int unsigned       RD_LAT  = 1,
  parameter int unsigned       WR_MODE = 0,
  parameter logic [WIDTH-1:0]  CLR_VAL = '0,
  localparam int unsigned      NB      = WIDTH / 8,
  localparam int unsigned      AW      = (LEN < 2) ? 1 : $clog2(LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [NB-1:0]     wr_be,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_e;

  localparam logic [AW:0]   LEN_W  = (AW+1)'(LEN);
  localparam logic [AW-1:0] LAST_A = AW'(LEN - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    clr_addr_q, clr_addr_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] mem [LEN];

  logic             wr_in_range, rd_in_range;
  logic             wr_acc, rd_acc, collide;
  logic [WIDTH-1:0] rd_old, wr_merged, rd_word;

  logic             pipe_v [RD_LAT];
  logic [WIDTH-1:0] pipe_d [RD_LAT];
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;

  // Address qualification and access acceptance
  assign wr_in_range = {1'b0, wr_addr} < LEN_W;
  assign rd_in_range = {1'b0, rd_addr} < LEN_W;
  assign wr_acc      = wr_en && !busy_q && wr_in_range;
  assign rd_acc      = rd_en && !busy_q;
  assign collide     = wr_acc && (wr_addr == rd_addr);

  assign rd_old = rd_in_range ? mem[rd_addr] : '0;

  // Merged word as it will look after this cycle's write (only meaningful on collision)
  always_comb begin
    wr_merged = rd_old;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) wr_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  assign rd_word = ((WR_MODE == 1) && collide) ? wr_merged : rd_old;

  // Storage: clear sweep has priority over the user write port
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_addr_q] <= CLR_VAL;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Clear engine state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  // Clear engine next state
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = busy_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_addr_q == LAST_A) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
          busy_d     = 1'b0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          busy_d     = 1'b1;
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
        busy_d     = 1'b1;
      end
    endcase
  end

  // Read pipeline: the word is captured at the accepting edge, then delayed RD_LAT stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      pipe_v[0] <= rd_acc;
      if (rd_acc) pipe_d[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      rd_valid_q <= pipe_v[RD_LAT-1];
      if (pipe_v[RD_LAT-1]) rd_data_q <= pipe_d[RD_LAT-1];
    end
  end

  assign busy     = busy_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
